// File: rtl/cache_controller.sv
// cache_controller: sequences one CPU load/store through a cache lookup,
// a memory read plus cache fill on a load miss, and a write-through to memory
// on every store (no write allocate).
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN;
// without it hit_count/miss_count read as zero and no counter flops exist.
//
// state   | meaning
// IDLE    | waiting for cpu_req, operands latched on acceptance
// LOOKUP  | cache_hit/cache_rdata sampled, store hit updates the cache
// MEM_RD  | memory read outstanding after a load miss
// FILL    | one-cycle strobe of fetched word into the cache
// MEM_WR  | write-through to memory outstanding
// RESPOND | one-cycle cpu_ready pulse
module cache_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  cache_we,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        MEM_RD  = 3'd2,
        FILL    = 3'd3,
        MEM_WR  = 3'd4,
        RESPOND = 3'd5
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  we_q;

    // State register; reset drops every FSM-derived output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand capture in IDLE, so a request that drops early still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (state == IDLE && cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            we_q    <= cpu_we;
        end
    end

    // Load result: hit data from the lookup or fetched data from memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (state == LOOKUP && !we_q && cache_hit) begin
            rdata_q <= cache_rdata;
        end else if (state == MEM_RD && mem_ack) begin
            rdata_q <= mem_rdata;
        end
    end

    // Next-state and strobe decode; mem_ack only matters in the memory states.
    always_comb begin
        state_nxt   = state;
        cpu_ready   = 1'b0;
        cache_we    = 1'b0;
        cache_wdata = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (we_q) begin
                    if (cache_hit) begin
                        cache_we    = 1'b1;
                        cache_wdata = wdata_q;
                    end
                    state_nxt = MEM_WR;
                end else begin
                    state_nxt = cache_hit ? RESPOND : MEM_RD;
                end
            end
            MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ack) state_nxt = FILL;
            end
            FILL: begin
                cache_we    = 1'b1;
                cache_wdata = rdata_q;
                state_nxt   = RESPOND;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_nxt = RESPOND;
            end
            RESPOND: begin
                cpu_ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_rdata  = rdata_q;
    assign cache_addr = addr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    // One count per lookup, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == LOOKUP) begin
            if (cache_hit) hit_q  <= hit_q + 32'd1;
            else           miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed test-plan transactions, a mid-read
// reset, then randomized loads/stores checked against a transaction-level model.
module tb_cache_controller;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic [31:0] cache_addr;
    logic        cache_hit;
    logic [31:0] cache_rdata;
    logic        cache_we;
    logic [31:0] cache_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          n_checks;
    int          n_errors;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    cache_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .cache_addr  (cache_addr),
        .cache_hit   (cache_hit),
        .cache_rdata (cache_rdata),
        .cache_we    (cache_we),
        .cache_wdata (cache_wdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_hits();
`ifdef CACHE_STATS_EN
        return m_hits;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_misses();
`ifdef CACHE_STATS_EN
        return m_misses;
`else
        return 32'd0;
`endif
    endfunction

    // One complete transaction; called at least 1 time unit after a clock edge.
    // Expected behaviour is derived from the transaction type and memory delay n.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic hit, input logic [31:0] crdata, input int n,
                           input logic [31:0] mrdata, input logic spurious, input logic drop_req);
        int          exp_lat;
        int          exp_cwe_cnt;
        int          exp_cwe_cyc;
        logic [31:0] exp_cwe_data;
        int          exp_mem_cnt;
        int          ready_cyc;
        logic [31:0] rdata_seen;
        int          cwe_cnt;
        int          cwe_cyc;
        logic [31:0] cwe_data;
        int          mem_cnt;
        int          rise_cyc;
        logic        mem_bad;
        logic        done;

        exp_lat      = we ? 3 + n : (hit ? 2 : 4 + n);
        exp_cwe_cnt  = (we ? hit : !hit) ? 1 : 0;
        exp_cwe_cyc  = we ? 1 : 3 + n;
        exp_cwe_data = we ? wdata : mrdata;
        exp_mem_cnt  = (!we && hit) ? 0 : n + 1;
        if (hit) m_hits++;
        else     m_misses++;

        ready_cyc = -1; rdata_seen = 32'hx; cwe_cnt = 0; cwe_cyc = -1; cwe_data = 32'hx;
        mem_cnt = 0; rise_cyc = -1; mem_bad = 1'b0; done = 1'b0;

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        cache_hit = hit; cache_rdata = crdata; mem_rdata = mrdata; mem_ack = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
            #1;
            if (drop_req && cyc == 1) begin
                cpu_req = 1'b0; cpu_addr = ~addr; cpu_wdata = ~wdata; cpu_we = ~we;
            end
            if (cyc == 1) chk("lookup_cache_addr", cache_addr, addr);
            if (cache_we === 1'b1) begin
                cwe_cnt++;
                if (cwe_cyc < 0) begin cwe_cyc = cyc; cwe_data = cache_wdata; end
            end
            if (mem_req === 1'b1) begin
                if (mem_cnt == 0) rise_cyc = cyc;
                if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wdata)) mem_bad = 1'b1;
                mem_cnt++;
                mem_ack = (cyc - rise_cyc == n);
            end else begin
                mem_ack = spurious ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            if (cpu_ready === 1'b1) begin
                ready_cyc  = cyc;
                rdata_seen = cpu_rdata;
                done       = 1'b1;
            end
            if (!done) @(posedge clk);
        end
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("ready_latency", 32'(ready_cyc), 32'(exp_lat));
        if (!we) chk("load_rdata", rdata_seen, hit ? crdata : mrdata);
        chk("cache_we_pulses", 32'(cwe_cnt), 32'(exp_cwe_cnt));
        if (exp_cwe_cnt == 1) begin
            chk("cache_we_cycle", 32'(cwe_cyc), 32'(exp_cwe_cyc));
            chk("cache_wdata", cwe_data, exp_cwe_data);
        end
        chk("mem_req_cycles", 32'(mem_cnt), 32'(exp_mem_cnt));
        if (exp_mem_cnt > 0) begin
            chk("mem_req_rise", 32'(rise_cyc), 32'd2);
            chk("mem_fields", 32'(mem_bad), 32'd0);
        end
        chk("ready_single", 32'(cpu_ready), 32'd0);
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        chk("hit_count", hit_count, exp_hits());
        chk("miss_count", miss_count, exp_misses());
    endtask

    initial begin
        logic quiet_bad;
        n_checks = 0; n_errors = 0; m_hits = 0; m_misses = 0;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cache_hit = 1'b0; cache_rdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        #12;
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_cache_addr", cache_addr, 32'd0);
        chk("rst_cache_we", 32'(cache_we), 32'd0);
        chk("rst_cache_wdata", cache_wdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a memory read.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; cache_hit = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        chk("midrd_mem_req_up", 32'(mem_req), 32'd1);
        chk("midrd_mem_addr", mem_addr, 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrd_mem_req_drop", 32'(mem_req), 32'd0);
        chk("midrd_mem_addr_clr", mem_addr, 32'd0);
        chk("midrd_miss_clr", miss_count, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        quiet_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (cpu_ready !== 1'b0 || cache_we !== 1'b0 || mem_req !== 1'b0) quiet_bad = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("post_reset_quiet", 32'(quiet_bad), 32'd0);
        chk("post_reset_rdata", cpu_rdata, 32'd0);

        // Test-plan transactions that also make up the stats scenario.
        run_txn(1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b0);
        run_txn(1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 3, 32'h12345678, 1'b0, 1'b0);
        run_txn(1'b1, 32'h44, 32'hA5A5A5A5, 1'b1, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        run_txn(1'b0, 32'h48, 32'h0, 1'b1, 32'h11112222, 0, 32'h0, 1'b1, 1'b0);
        run_txn(1'b0, 32'h4C, 32'h0, 1'b1, 32'h33334444, 0, 32'h0, 1'b0, 1'b1);
        run_txn(1'b0, 32'h50, 32'h0, 1'b0, 32'h0, 0, 32'hCAFEF00D, 1'b1, 1'b0);
`ifdef CACHE_STATS_EN
        chk("stats_hits", hit_count, 32'd4);
        chk("stats_misses", miss_count, 32'd2);
`else
        chk("stats_hits_off", hit_count, 32'd0);
        chk("stats_misses_off", miss_count, 32'd0);
`endif
        run_txn(1'b1, 32'h54, 32'h5A5A5A5A, 1'b0, 32'h0, 2, 32'h0, 1'b1, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(1, 0)), $urandom, $urandom, 1'($urandom_range(1, 0)),
                    $urandom, int'($urandom_range(4, 0)), $urandom,
                    1'($urandom_range(1, 0)), 1'($urandom_range(7, 0) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
